// File: rtl/dmem_timer_resp.sv
// Memory-mapped prescaled down-counter timer on the data-memory bus.
// Auto-reload or one-shot, sticky expiry flag, and a level interrupt.
module dmem_timer_resp #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        sel,
    output logic        irq
);

    localparam logic [5:0] OffCtrl     = 6'h00;
    localparam logic [5:0] OffLoad     = 6'h01;
    localparam logic [5:0] OffCount    = 6'h02;
    localparam logic [5:0] OffStatus   = 6'h03;
    localparam logic [5:0] OffPrescale = 6'h04;

    logic                  en_q, en_d;
    logic                  auto_q, auto_d;
    logic                  irq_en_q, irq_en_d;
    logic [31:0]           load_q, load_d;
    logic [31:0]           count_q, count_d;
    logic                  expired_q, expired_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;

    logic [5:0] off;
    logic       we;
    logic       tick;
    logic       unused_addr_lsbs;

    assign sel              = (dataadr[31:8] == BASE_ADDR[31:8]);
    assign off              = dataadr[7:2];
    assign we               = memwrite & sel;
    assign tick             = en_q && (pcnt_q == prescale_q);
    assign irq              = expired_q & irq_en_q;
    assign unused_addr_lsbs = ^dataadr[1:0];

    always_comb begin
        en_d       = en_q;
        auto_d     = auto_q;
        irq_en_d   = irq_en_q;
        load_d     = load_q;
        count_d    = count_q;
        expired_d  = expired_q;
        prescale_d = prescale_q;

        // Clear is applied before the tick so a coincident expiry keeps the flag set.
        if (we && (off == OffStatus) && writedata[0]) begin
            expired_d = 1'b0;
        end

        if (tick) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else begin
                expired_d = 1'b1;
                if (auto_q) begin
                    count_d = load_q;
                end else begin
                    en_d = 1'b0;
                end
            end
        end

        // Bus writes come last so they override tick side effects on COUNT and CTRL.
        if (we) begin
            case (off)
                OffCtrl: begin
                    en_d     = writedata[0];
                    auto_d   = writedata[1];
                    irq_en_d = writedata[2];
                end
                OffLoad:     load_d     = writedata;
                OffCount:    count_d    = writedata;
                OffPrescale: prescale_d = writedata[PRESCALE_W-1:0];
                default: ;
            endcase
        end

        // Restarts from zero on a 0->1 enable and parks at zero whenever stopped.
        pcnt_d = (en_q && en_d && !tick) ? pcnt_q + 1'b1 : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q       <= 1'b0;
            auto_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            load_q     <= 32'd0;
            count_q    <= 32'd0;
            expired_q  <= 1'b0;
            prescale_q <= '0;
            pcnt_q     <= '0;
        end else begin
            en_q       <= en_d;
            auto_q     <= auto_d;
            irq_en_q   <= irq_en_d;
            load_q     <= load_d;
            count_q    <= count_d;
            expired_q  <= expired_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
        end
    end

    always_comb begin
        readdata = 32'd0;
        if (sel) begin
            case (off)
                OffCtrl:     readdata = {29'd0, irq_en_q, auto_q, en_q};
                OffLoad:     readdata = load_q;
                OffCount:    readdata = count_q;
                OffStatus:   readdata = {31'd0, expired_q};
                OffPrescale: readdata = 32'(prescale_q);
                default:     readdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_timer_resp.sv
// Directed bench for dmem_timer_resp: register access, one-shot, auto-reload and races.
module tb_dmem_timer_resp;

    localparam logic [31:0] A_CTRL     = 32'hFFFF_FF00;
    localparam logic [31:0] A_LOAD     = 32'hFFFF_FF04;
    localparam logic [31:0] A_COUNT    = 32'hFFFF_FF08;
    localparam logic [31:0] A_STATUS   = 32'hFFFF_FF0C;
    localparam logic [31:0] A_PRESCALE = 32'hFFFF_FF10;
    localparam logic [31:0] A_HOLE     = 32'hFFFF_FF14;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = 32'd0;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        sel;
    logic        irq;

    int vectors = 0;
    int miscompares = 0;

    dmem_timer_resp dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .readdata  (readdata),
        .sel       (sel),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // Lands on the first rising edge after the next falling edge; returns 1ns after it.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        memwrite  = 1'b1;
        dataadr   = addr;
        writedata = data;
        @(posedge clk);
        #1;
        memwrite  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        dataadr = addr;
        #1;
        data = readdata;
    endtask

    task automatic test_reset;
        logic [31:0] addrs [6];
        logic [31:0] v;
        addrs = '{A_CTRL, A_LOAD, A_COUNT, A_STATUS, A_PRESCALE, A_HOLE};
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rd(addrs[i], v);
            vectors++;
            if (v !== 32'd0) begin
                miscompares++;
                $display("FAIL reset_read[%0d] got %h want 00000000", i, v);
            end
        end
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_irq got %b want 0", irq);
        end
        rd(32'hFFFF_FF10, v);
        vectors++;
        if (sel !== 1'b1) begin
            miscompares++;
            $display("FAIL sel_in_window got %b want 1", sel);
        end
        rd(32'hFFFF_FE10, v);
        vectors++;
        if (sel !== 1'b0 || v !== 32'd0) begin
            miscompares++;
            $display("FAIL sel_below_window got sel=%b rd=%h want sel=0 rd=0", sel, v);
        end
    endtask

    task automatic test_oneshot;
        logic [31:0] v;
        logic [31:0] exp_seq [3];
        exp_seq = '{32'd2, 32'd1, 32'd0};
        bus_write(A_PRESCALE, 32'd0);
        bus_write(A_COUNT, 32'd3);
        bus_write(A_CTRL, 32'h5);
        rd(A_COUNT, v);
        vectors++;
        if (v !== 32'd3) begin
            miscompares++;
            $display("FAIL oneshot_start got %h want 3", v);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            rd(A_COUNT, v);
            vectors++;
            if (v !== exp_seq[i]) begin
                miscompares++;
                $display("FAIL oneshot_count[%0d] got %h want %h", i, v, exp_seq[i]);
            end
        end
        rd(A_STATUS, v);
        vectors++;
        if (v !== 32'd0 || irq !== 1'b0) begin
            miscompares++;
            $display("FAIL oneshot_early got status=%h irq=%b want 0/0", v, irq);
        end
        @(posedge clk);
        #1;
        rd(A_STATUS, v);
        vectors++;
        if (v !== 32'd1 || irq !== 1'b1) begin
            miscompares++;
            $display("FAIL oneshot_expire got status=%h irq=%b want 1/1", v, irq);
        end
        rd(A_CTRL, v);
        vectors++;
        if (v !== 32'h4) begin
            miscompares++;
            $display("FAIL oneshot_ctrl got %h want 4", v);
        end
        @(posedge clk);
        #1;
        rd(A_COUNT, v);
        vectors++;
        if (v !== 32'd0) begin
            miscompares++;
            $display("FAIL oneshot_hold got %h want 0", v);
        end
        bus_write(A_STATUS, 32'd1);
        rd(A_STATUS, v);
        vectors++;
        if (v !== 32'd0 || irq !== 1'b0) begin
            miscompares++;
            $display("FAIL oneshot_clear got status=%h irq=%b want 0/0", v, irq);
        end
        bus_write(A_CTRL, 32'd0);
    endtask

    // Ends 1ns+1 read after edge E22 relative to the CTRL write edge E0.
    task automatic test_autoreload;
        logic [31:0] v;
        logic [31:0] exp_cnt;
        bus_write(A_PRESCALE, 32'd4);
        bus_write(A_LOAD, 32'd2);
        bus_write(A_COUNT, 32'd0);
        bus_write(A_CTRL, 32'h3);
        for (int k = 1; k <= 22; k++) begin
            @(posedge clk);
            #1;
            if (k < 5) exp_cnt = 32'd0;
            else if (((k - 5) / 5) % 3 == 0) exp_cnt = 32'd2;
            else if (((k - 5) / 5) % 3 == 1) exp_cnt = 32'd1;
            else exp_cnt = 32'd0;
            rd(A_COUNT, v);
            vectors++;
            if (v !== exp_cnt || irq !== 1'b0) begin
                miscompares++;
                $display("FAIL auto_count[k=%0d] got %h irq=%b want %h irq=0", k, v, irq,
                         exp_cnt);
            end
            if (k == 4 || k == 5) begin
                rd(A_STATUS, v);
                vectors++;
                if (v !== ((k == 5) ? 32'd1 : 32'd0)) begin
                    miscompares++;
                    $display("FAIL auto_expired[k=%0d] got %h want %0d", k, v, (k == 5));
                end
            end
        end
    endtask

    task automatic test_status_race;
        logic [31:0] v;
        bus_write(A_STATUS, 32'd1);  // lands on E23, no tick there
        rd(A_STATUS, v);
        vectors++;
        if (v !== 32'd0) begin
            miscompares++;
            $display("FAIL status_clear got %h want 0", v);
        end
        repeat (11) @(posedge clk);
        #1;
        bus_write(A_STATUS, 32'd1);  // lands on E35, the expiry tick
        rd(A_STATUS, v);
        vectors++;
        if (v !== 32'd1) begin
            miscompares++;
            $display("FAIL status_set_wins got %h want 1", v);
        end
        rd(A_COUNT, v);
        vectors++;
        if (v !== 32'd2) begin
            miscompares++;
            $display("FAIL status_reload got %h want 2", v);
        end
        bus_write(A_STATUS, 32'd1);  // E36
        rd(A_STATUS, v);
        vectors++;
        if (v !== 32'd0 || irq !== 1'b0) begin
            miscompares++;
            $display("FAIL status_late_clear got status=%h irq=%b want 0/0", v, irq);
        end
        bus_write(A_CTRL, 32'd0);
    endtask

    task automatic test_count_override;
        logic [31:0] v;
        bus_write(A_PRESCALE, 32'd0);
        bus_write(A_COUNT, 32'd5);
        bus_write(A_CTRL, 32'h1);
        bus_write(A_COUNT, 32'h10);  // coincides with a tick while COUNT == 5
        rd(A_COUNT, v);
        vectors++;
        if (v !== 32'h10) begin
            miscompares++;
            $display("FAIL count_write_wins got %h want 10", v);
        end
        bus_write(A_CTRL, 32'd0);
        rd(A_COUNT, v);
        vectors++;
        if (v !== 32'h0F) begin
            miscompares++;
            $display("FAIL count_last_tick got %h want 0f", v);
        end
        @(negedge clk);
        memwrite  = 1'b1;
        dataadr   = 32'h0000_0008;
        writedata = 32'h0000_1234;
        #1;
        vectors++;
        if (sel !== 1'b0 || readdata !== 32'd0) begin
            miscompares++;
            $display("FAIL outside_sel got sel=%b rd=%h want sel=0 rd=0", sel, readdata);
        end
        @(posedge clk);
        #1;
        memwrite = 1'b0;
        rd(A_COUNT, v);
        vectors++;
        if (v !== 32'h0F) begin
            miscompares++;
            $display("FAIL outside_write got %h want 0f", v);
        end
        rd(A_CTRL, v);
        vectors++;
        if (v !== 32'd0) begin
            miscompares++;
            $display("FAIL outside_ctrl got %h want 0", v);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        logic [31:0] addrs [5];
        addrs = '{A_CTRL, A_LOAD, A_COUNT, A_STATUS, A_PRESCALE};
        bus_write(A_PRESCALE, 32'd0);
        bus_write(A_LOAD, 32'd7);
        bus_write(A_COUNT, 32'd9);
        bus_write(A_CTRL, 32'h7);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset     = 1'b1;
        memwrite  = 1'b1;
        dataadr   = A_CTRL;
        writedata = 32'h7;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        memwrite = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rd(addrs[i], v);
            vectors++;
            if (v !== 32'd0) begin
                miscompares++;
                $display("FAIL midreset_read[%0d] got %h want 0", i, v);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        rd(A_STATUS, v);
        vectors++;
        if (v !== 32'd0 || irq !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_no_tick got status=%h irq=%b want 0/0", v, irq);
        end
        rd(A_COUNT, v);
        vectors++;
        if (v !== 32'd0) begin
            miscompares++;
            $display("FAIL midreset_count got %h want 0", v);
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_autoreload();
        test_status_race();
        test_count_override();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
